program_mem: RTL and testbench
==============================

PROGRAM_MEM -- requirements
Module: program_mem

Interface
REQ-001 Parameter ADDR_W, default 3, SHALL set the address width; depth SHALL be DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction width; it SHALL be a multiple of 8 and at least 8; NB = DATA_W/8 bytes per word.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 fetch_req  input  1  SHALL be the read request, sampled on the clock edge.
REQ-006 fetch_addr  input  ADDR_W  SHALL be the word address for fetch_req.
REQ-007 instruction  output  DATA_W  SHALL be the registered read data.
REQ-008 fetch_valid  output  1  SHALL qualify instruction.
REQ-009 load_en  input  1  SHALL be the level request to enter and stay in load mode.
REQ-010 load_valid  input  1  SHALL qualify load_byte.
REQ-011 load_byte  input  8  SHALL be the serial program byte.
REQ-012 load_ready  output  1  SHALL indicate that a byte can be accepted this cycle.
REQ-013 load_done  output  1  SHALL be a one-cycle pulse when all DEPTH words have been written.
REQ-014 load_err  output  1  SHALL be a one-cycle pulse when load is aborted with a partial word.
REQ-015 busy  output  1  SHALL be 1 in any state other than RUN.

Function
REQ-016 States SHALL be RUN, LOAD and FULL; reset state SHALL be RUN.
REQ-017 RUN to LOAD SHALL occur when load_en=1; on entry, word pointer wp and byte count bc SHALL be cleared to 0.
REQ-018 In LOAD, load_ready SHALL be 1; a byte SHALL be accepted on an edge where load_valid=1 and load_ready=1.
REQ-019 Bytes SHALL assemble MSB first: byte k of a word SHALL land in bits [DATA_W-1-8k -: 8].
REQ-020 On acceptance of byte NB-1, the full word SHALL be written to mem[wp] on that edge, bc SHALL become 0, and wp SHALL increment.
REQ-021 When wp=DEPTH-1 completes, load_done SHALL pulse in the following cycle, the state SHALL become FULL, and wp SHALL NOT wrap.
REQ-022 FULL SHALL hold load_ready=0 and ignore load_valid; FULL to RUN SHALL occur when load_en=0.
REQ-023 LOAD to RUN SHALL occur when load_en=0. If bc!=0, the partial word SHALL be discarded, memory SHALL be unchanged, and load_err SHALL pulse one cycle. If bc=0, there SHALL be no pulse.
REQ-024 If load_en=0 and load_valid=1 occur on the same edge in LOAD, the byte SHALL NOT be accepted.
REQ-025 In RUN, fetch_req=1 at edge N SHALL produce instruction=mem[fetch_addr] and fetch_valid=1 after edge N (1-cycle latency).
REQ-026 Back-to-back fetches SHALL be supported at one per cycle.
REQ-027 fetch_valid SHALL be 0 in cycles following edges with no accepted request.
REQ-028 instruction SHALL hold its last value when fetch_valid=0.
REQ-029 In LOAD and FULL, fetch_req SHALL be ignored (fetch_valid=0).
REQ-030 A fetch issued on the same edge as the RUN to LOAD transition SHALL still complete.
REQ-031 Memory contents SHALL power up as all-zero words.
REQ-032 Memory contents SHALL NOT be altered by reset; only LOAD writes memory.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately force state=RUN, wp=0, bc=0, instruction=0, fetch_valid=0, load_ready=0, load_done=0, load_err=0, busy=0.
REQ-034 Reset mid-LOAD SHALL discard any partial word without a load_err pulse.
REQ-035 Words completed before reset SHALL remain in memory.
REQ-036 The first edge after rst_n rises SHALL be able to accept fetch_req or load_en.

Verification
REQ-037 Power-up, reset release, fetch addr 5 -> fetch_valid=1 next cycle with instruction=0x00000000; all outputs 0 during reset.
REQ-038 load_en=1, 32 bytes for words {0x1100000A,0x1100000D,0x21200000,0,0,0,0,0xF1000000} -> load_done pulse after byte 32, state FULL, load_ready=0; drop load_en, fetch addrs 0,2,7 back-to-back -> 0x1100000A,0x21200000,0xF1000000 on three consecutive cycles.
REQ-039 load_en=1, bytes 0xAA,0xBB, then load_en=0 -> load_err single pulse, no load_done; fetch addr 0 returns the previous content unchanged.
REQ-040 During LOAD, fetch_req=1 for 3 cycles -> fetch_valid stays 0 and instruction holds its value.
REQ-041 Reset asserted after 6 bytes (word 0 complete, word 1 partial) -> outputs cleared asynchronously; fetch addr 0 returns the new word 0, fetch addr 1 returns the old word 1.
REQ-042 load_valid held with gaps (valid 1,0,1,1,0,...) -> only qualified bytes are assembled; word values match those of the gap-free load.

Source files
------------

// File: rtl/program_mem_if.sv
// Fetch and serial-load signal bundle for program_mem.
// The master side is the fetch/load client and the slave side is the memory.
interface program_mem_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 32
) ();
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instruction;
    logic              fetch_valid;
    logic              load_en;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              load_done;
    logic              load_err;
    logic              busy;

    modport master (
        output fetch_req, fetch_addr, load_en, load_valid, load_byte,
        input  instruction, fetch_valid, load_ready, load_done, load_err, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, load_en, load_valid, load_byte,
        output instruction, fetch_valid, load_ready, load_done, load_err, busy
    );
endinterface

// File: rtl/program_mem.sv
// Instruction memory with a one-cycle registered fetch port and a serial byte loader.
// Words are assembled MSB first and committed only when complete.
module program_mem #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    program_mem_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned BC_W  = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {StRun, StLoad, StFull} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wp_q;
    logic [BC_W-1:0]   bc_q;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] instruction_q;
    logic              fetch_valid_q;
    logic              load_done_q;
    logic              load_err_q;
    logic              byte_acc;
    logic              word_last;
    logic              mem_we;

    // Contents start as zero words and are deliberately outside the reset domain.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    always_comb begin
        byte_acc  = (state_q == StLoad) && bus.load_en && bus.load_valid;
        word_last = (bc_q == BC_W'(NB - 1));
        mem_we    = byte_acc && word_last;
        word_d    = word_q;
        word_d[DATA_W - 1 - 8 * int'(bc_q) -: 8] = bus.load_byte;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wp_q] <= word_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            wp_q          <= '0;
            bc_q          <= '0;
            word_q        <= '0;
            instruction_q <= '0;
            fetch_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            fetch_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
            unique case (state_q)
                StRun: begin
                    // A fetch on the entry edge into LOAD still completes.
                    if (bus.fetch_req) begin
                        instruction_q <= mem_q[bus.fetch_addr];
                        fetch_valid_q <= 1'b1;
                    end
                    if (bus.load_en) begin
                        state_q <= StLoad;
                        wp_q    <= '0;
                        bc_q    <= '0;
                    end
                end
                StLoad: begin
                    if (!bus.load_en) begin
                        state_q    <= StRun;
                        load_err_q <= (bc_q != '0);
                        bc_q       <= '0;
                    end else if (bus.load_valid) begin
                        word_q <= word_d;
                        if (word_last) begin
                            bc_q <= '0;
                            if (wp_q == ADDR_W'(DEPTH - 1)) begin
                                state_q     <= StFull;
                                load_done_q <= 1'b1;
                            end else begin
                                wp_q <= wp_q + ADDR_W'(1);
                            end
                        end else begin
                            bc_q <= bc_q + BC_W'(1);
                        end
                    end
                end
                StFull: begin
                    if (!bus.load_en) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.instruction = instruction_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.load_ready  = (state_q == StLoad);
    assign bus.load_done   = load_done_q;
    assign bus.load_err    = load_err_q;
    assign bus.busy        = (state_q != StRun);
endmodule

// File: tb/tb_program_mem.sv
// Directed bench for program_mem: fetch latency, serial load, abort, reset mid-load, gapped load.
module tb_program_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] words [8] = '{32'h1100000A, 32'h1100000D, 32'h21200000, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'hF1000000};

    program_mem_if #(.ADDR_W(3), .DATA_W(32)) bus ();

    program_mem #(.ADDR_W(3), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [2:0] addr, input logic [31:0] exp, input string name);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        cycle();
        bus.fetch_req = 1'b0;
        checks++;
        if (bus.fetch_valid !== 1'b1 || bus.instruction !== exp) begin
            errors++;
            $display("FAIL %s: valid=%b instr=%h, required valid=1 instr=%h",
                     name, bus.fetch_valid, bus.instruction, exp);
        end
    endtask

    task automatic test_reset();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_en    = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_byte  = '0;
        #12;
        checks++;
        if ({bus.fetch_valid, bus.load_ready, bus.load_done, bus.load_err, bus.busy} !== 5'b0 ||
            bus.instruction !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b instr=%h, required all zero",
                     {bus.fetch_valid, bus.load_ready, bus.load_done, bus.load_err, bus.busy},
                     bus.instruction);
        end
        rst_n = 1'b1;
        do_fetch(3'd5, 32'h0, "powerup_fetch5");
        cycle();
        checks++;
        if (bus.fetch_valid !== 1'b0 || bus.instruction !== 32'h0) begin
            errors++;
            $display("FAIL idle_after_fetch: valid=%b instr=%h, required valid=0 instr=0",
                     bus.fetch_valid, bus.instruction);
        end
    endtask

    task automatic test_full_load();
        bus.load_en = 1'b1;
        cycle();
        checks++;
        if (bus.load_ready !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_entry: ready=%b busy=%b, required 1 1", bus.load_ready, bus.busy);
        end
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] wv;
                wv = words[w];
                bus.load_valid = 1'b1;
                bus.load_byte  = wv[31 - 8 * k -: 8];
                cycle();
                if (w == 7 && k == 2) begin
                    checks++;
                    if (bus.load_done !== 1'b0) begin
                        errors++;
                        $display("FAIL early_done: load_done=%b, required 0", bus.load_done);
                    end
                end
            end
        end
        checks++;
        if (bus.load_done !== 1'b1 || bus.load_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_done_pulse: done=%b ready=%b busy=%b, required 1 0 1",
                     bus.load_done, bus.load_ready, bus.busy);
        end
        bus.load_byte = 8'h55;
        cycle();
        checks++;
        if (bus.load_done !== 1'b0 || bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: done=%b ready=%b, required 0 0",
                     bus.load_done, bus.load_ready);
        end
        bus.load_valid = 1'b0;
        bus.load_en    = 1'b0;
        cycle();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL full_exit: busy=%b, required 0", bus.busy);
        end
        do_fetch(3'd0, 32'h1100000A, "b2b_fetch0");
        do_fetch(3'd2, 32'h21200000, "b2b_fetch2");
        do_fetch(3'd7, 32'hF1000000, "b2b_fetch7");
        cycle();
        checks++;
        if (bus.fetch_valid !== 1'b0 || bus.instruction !== 32'hF1000000) begin
            errors++;
            $display("FAIL instr_hold: valid=%b instr=%h, required valid=0 instr=f1000000",
                     bus.fetch_valid, bus.instruction);
        end
    endtask

    task automatic test_partial_abort();
        bus.load_en = 1'b1;
        cycle();
        bus.load_valid = 1'b1;
        bus.load_byte  = 8'hAA;
        cycle();
        bus.load_byte = 8'hBB;
        cycle();
        // Byte presented with the exit edge must not be taken.
        bus.load_byte = 8'hCC;
        bus.load_en   = 1'b0;
        cycle();
        bus.load_valid = 1'b0;
        checks++;
        if (bus.load_err !== 1'b1 || bus.load_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_err: err=%b done=%b busy=%b, required 1 0 0",
                     bus.load_err, bus.load_done, bus.busy);
        end
        cycle();
        checks++;
        if (bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_single: err=%b, required 0", bus.load_err);
        end
        do_fetch(3'd0, 32'h1100000A, "abort_mem_unchanged");
        bus.load_en = 1'b1;
        cycle();
        bus.load_en = 1'b0;
        cycle();
        checks++;
        if (bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL empty_abort: err=%b, required 0", bus.load_err);
        end
    endtask

    task automatic test_fetch_in_load();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 3'd2;
        bus.load_en    = 1'b1;
        cycle();
        checks++;
        if (bus.fetch_valid !== 1'b1 || bus.instruction !== 32'h21200000 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL fetch_on_entry: valid=%b instr=%h busy=%b, required 1 21200000 1",
                     bus.fetch_valid, bus.instruction, bus.busy);
        end
        bus.fetch_addr = 3'd7;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (bus.fetch_valid !== 1'b0 || bus.instruction !== 32'h21200000) begin
                errors++;
                $display("FAIL fetch_in_load[%0d]: valid=%b instr=%h, required 0 21200000",
                         i, bus.fetch_valid, bus.instruction);
            end
        end
        bus.fetch_req = 1'b0;
        bus.load_en   = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid_load();
        logic [47:0] stream;
        stream = 48'hDEADBEEF_1234;
        bus.load_en = 1'b1;
        cycle();
        for (int i = 0; i < 6; i++) begin
            bus.load_valid = 1'b1;
            bus.load_byte  = stream[47 - 8 * i -: 8];
            cycle();
        end
        #2;
        bus.load_en    = 1'b0;
        bus.load_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        checks++;
        if ({bus.fetch_valid, bus.load_ready, bus.load_done, bus.load_err, bus.busy} !== 5'b0 ||
            bus.instruction !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: flags=%b instr=%h, required all zero",
                     {bus.fetch_valid, bus.load_ready, bus.load_done, bus.load_err, bus.busy},
                     bus.instruction);
        end
        #2;
        rst_n = 1'b1;
        do_fetch(3'd0, 32'hDEADBEEF, "reset_kept_word0");
        checks++;
        if (bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_err: err=%b, required 0", bus.load_err);
        end
        do_fetch(3'd1, 32'h1100000D, "reset_old_word1");
    endtask

    task automatic test_gapped_load();
        logic [4:0] pat;
        int         sent;
        int         step;
        pat  = 5'b01101;
        sent = 0;
        step = 0;
        bus.load_en = 1'b1;
        cycle();
        while (sent < 32) begin
            if (pat[step % 5]) begin
                logic [31:0] wv;
                wv = words[sent / 4];
                bus.load_valid = 1'b1;
                bus.load_byte  = wv[31 - 8 * (sent % 4) -: 8];
                sent++;
            end else begin
                bus.load_valid = 1'b0;
                bus.load_byte  = 8'hFF;
            end
            cycle();
            step++;
        end
        bus.load_valid = 1'b0;
        checks++;
        if (bus.load_done !== 1'b1) begin
            errors++;
            $display("FAIL gapped_done: load_done=%b, required 1", bus.load_done);
        end
        bus.load_en = 1'b0;
        cycle();
        for (int a = 0; a < 8; a++) begin
            do_fetch(3'(a), words[a], "gapped_word");
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_partial_abort();
        test_fetch_in_load();
        test_reset_mid_load();
        test_gapped_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
